dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the pipeline MEM stage and a slow
//  line-based backing memory. It replaces the single-cycle data memory port. Hits complete in the
//  same cycle. Misses assert stall_o, which the CPU ORs into its PC/IF_ID/ID_EX/EX_MEM/MEM_WB
//  hold logic, until the line has been written back (if dirty) and refilled.
// PARAMETERS
//  SETS        16   number of lines; power of 2; index = addr_i[3+log2(SETS):4]
//  TAG_W       24   tag width = 32 - 4 - log2(SETS); line = 4 words (128 b)
// PORTS
//  clk_i         in   1    clock, rising edge
//  rst_i         in   1    asynchronous reset, active-high
//  req_i         in   1    CPU access valid this cycle (MemRead | MemWrite)
//  we_i          in   1    1 = store, 0 = load
//  addr_i        in   32   byte address; [1:0] ignored, [3:2] word offset
//  wdata_i       in   32   store data
//  rdata_o       out  32   load data, valid when req_i & ~we_i & ~stall_o
//  stall_o       out  1    CPU must hold all pipeline registers and resend the same request
//  mem_req_o     out  1    backing-memory request, held high until mem_ack_i
//  mem_we_o      out  1    1 = line write-back, 0 = line fetch
//  mem_addr_o    out  32   line-aligned address ([3:0] = 0)
//  mem_wdata_o   out  128  victim line for write-back, word0 in [31:0]
//  mem_rdata_i   in   128  refill line, valid in the cycle mem_ack_i = 1
//  mem_ack_i     in   1    one-cycle pulse: current memory transaction is complete
// BEHAVIOUR
//  - Storage: per set valid, dirty, tag[TAG_W-1:0], data[127:0].
//  - hit = req_i & valid[idx] & (tag[idx] == addr_i[31:32-TAG_W]); evaluated combinationally.
//  - State machine: IDLE, WRITEBACK, ALLOCATE.
//  - IDLE:
//    - Load hit: rdata_o = selected word, stall_o = 0 (zero-cycle latency).
//    - Store hit: at the clock edge, the word is written and dirty set; stall_o = 0.
//    - Miss: stall_o = 1 combinationally in the same cycle. Next state is WRITEBACK if
//      valid & dirty, else ALLOCATE.
//  - WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {old_tag, idx, 4'b0},
//    mem_wdata_o = line. On mem_ack_i: clear dirty, go to ALLOCATE.
//  - ALLOCATE: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {addr_i[31:4], 4'b0}.
//    On mem_ack_i: load mem_rdata_i into the line, set valid and tag, clear dirty, go to IDLE.
//    Next cycle in IDLE is a hit, so the CPU's held request completes there, including a store
//    merge.
//  - stall_o = 1 in every cycle of WRITEBACK and ALLOCATE, and on a miss in IDLE.
//  - Outputs are registered from state, except stall_o, rdata_o and hit, which are combinational.
//  - Miss address is latched on leaving IDLE. Memory traffic uses the latched address; addr_i
//    changes while stalled are ignored until IDLE.
//  - mem_ack_i in IDLE is ignored. mem_ack_i arriving the same cycle mem_req_o first rises is legal.
//  - If req_i drops mid-miss, the miss still completes (line is filled); there is no abort.
//  - Reset (any time, including mid-transaction):
//    - state = IDLE; all valid and dirty = 0.
//    - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, rdata_o = 0, stall_o = 0.
//    - Data and tag arrays are not cleared.
//  - Only one outstanding memory transaction at a time. No write buffer.
// TESTING
//  1. Cold load 0x100 after reset -> stall_o=1, ALLOCATE mem_addr_o=0x100 (no WRITEBACK); ack with
//     line {4,3,2,1} -> next cycle rdata_o=1, stall_o=0.
//  2. Load 0x104 after test 1 -> hit, rdata_o=2, stall_o=0, mem_req_o stays 0.
//  3. Store 0xAB to 0x108 (hit), then load 0x908 (same idx, tag differs) -> WRITEBACK addr 0x100,
//     wdata word2=0xAB; then ALLOCATE addr 0x900.
//  4. Store miss to clean set 0x200 with data 0x55 -> ALLOCATE only; after refill the store merges,
//     and a later load of 0x200 returns 0x55 with the line dirty.
//  5. Assert rst_i during ALLOCATE with mem_req_o=1 -> mem_req_o and stall_o drop immediately;
//     load 0x100 afterwards misses.
//  6. mem_ack_i delayed 20 cycles with addr_i toggled while stalled -> stall_o held for all 20
//     cycles, mem_addr_o stable at the latched line.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word lines.
// Hits finish combinationally; a miss stalls the pipeline while one line transfer runs.
module dcache_controller #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned TAG_W = 32 - 4 - $clog2(SETS)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_i,
  input  logic         we_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned LineW = TAG_W + IdxW;

  typedef enum logic [1:0] {StIdle, StWriteback, StAllocate} state_e;

  state_e state_q, state_d;

  logic [SETS-1:0]  valid_q, dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [127:0]     data_q [SETS];

  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [127:0]     mem_wdata_q, mem_wdata_d;
  logic [LineW-1:0] miss_line_q;

  logic [IdxW-1:0]  req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_off;
  logic [IdxW-1:0]  miss_idx;
  logic [TAG_W-1:0] miss_tag;
  logic [127:0]     req_line;
  logic [31:0]      req_word;
  logic             hit;
  logic             store_hit;
  logic             fill;
  logic             wb_done;
  logic             unused_addr;

  assign req_idx  = addr_i[4 +: IdxW];
  assign req_tag  = addr_i[31 -: TAG_W];
  assign req_off  = addr_i[3:2];
  assign miss_idx = miss_line_q[IdxW-1:0];
  assign miss_tag = miss_line_q[LineW-1:IdxW];

  assign unused_addr = ^addr_i[1:0];

  assign hit       = req_i & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
  assign store_hit = (state_q == StIdle) & hit & we_i;
  assign fill      = (state_q == StAllocate) & mem_ack_i;
  assign wb_done   = (state_q == StWriteback) & mem_ack_i;

  assign req_line = data_q[req_idx];
  assign req_word = req_line[{req_off, 5'b00000} +: 32];

  assign rdata_o = ((state_q == StIdle) && hit && !we_i) ? req_word : 32'h0;
  // Reset masks the miss term so a held request cannot stall while reset is asserted.
  assign stall_o = !rst_i && ((state_q != StIdle) || (req_i && !hit));

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      StIdle: begin
        if (req_i && !hit) begin
          mem_req_d = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d     = StWriteback;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[req_idx], req_idx, 4'b0000};
            mem_wdata_d = data_q[req_idx];
          end else begin
            state_d     = StAllocate;
            mem_we_d    = 1'b0;
            mem_addr_d  = {addr_i[31:4], 4'b0000};
            mem_wdata_d = '0;
          end
        end
      end
      StWriteback: begin
        if (mem_ack_i) begin
          state_d     = StAllocate;
          mem_we_d    = 1'b0;
          mem_addr_d  = {miss_line_q, 4'b0000};
          mem_wdata_d = '0;
        end
      end
      StAllocate: begin
        if (mem_ack_i) begin
          state_d    = StIdle;
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          mem_addr_d = 32'h0;
        end
      end
      default: begin
        state_d   = StIdle;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= '0;
      miss_line_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      // Latch the missing line so later addr_i changes cannot redirect the transfer.
      if (state_q == StIdle && state_d != StIdle) begin
        miss_line_q <= addr_i[31:4];
      end
      if (store_hit) begin
        dirty_q[req_idx] <= 1'b1;
      end
      if (wb_done) begin
        dirty_q[miss_idx] <= 1'b0;
      end
      if (fill) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data storage is not reset; the valid bits gate every use of it.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      data_q[miss_idx] <= mem_rdata_i;
      tag_q[miss_idx]  <= miss_tag;
    end else if (store_hit) begin
      data_q[req_idx][{req_off, 5'b00000} +: 32] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a flat architectural memory plus a direct-mapped
// residency model predict memory traffic and load data; a monitor checks what the DUT presents.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i, req_i, we_i;
  logic [31:0]  addr_i, wdata_i, rdata_o, mem_addr_o;
  logic         stall_o, mem_req_o, mem_we_o;
  logic         mem_ack_i = 1'b0;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i = '0;

  dcache_controller dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  // Expected events: 0 write-back, 1 line fetch, 2 load completion, 3 store completion.
  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [127:0] data;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic [31:0] bmem [logic [31:0]];
  logic [31:0] arch [logic [31:0]];
  bit   [15:0] mvalid, mdirty;
  logic [23:0] mtag [16];

  int fixed_delay = -1;
  bit spurious_en = 1'b0;
  int wait_cnt = 0;
  int cur_delay = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] bm_rd(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    if (arch.exists(a)) return arch[a];
    return init_word(a);
  endfunction

  function automatic logic [127:0] bm_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = bm_rd(a + 32'(4 * w));
    return l;
  endfunction

  function automatic logic [127:0] arch_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = arch_rd(a + 32'(4 * w));
    return l;
  endfunction

  function automatic int pick_delay();
    if (fixed_delay >= 0) return fixed_delay;
    return int'($urandom_range(0, 3));
  endfunction

  function automatic bit predict_miss(input logic [31:0] a);
    return !(mvalid[a[7:4]] && mtag[a[7:4]] == a[31:8]);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Cache is transparent: loads see the latest architectural value; a miss on a set
  // holding a different dirty line first writes that line back.
  task automatic model_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                              input bit abort, output bit miss);
    logic [3:0]  idx;
    logic [31:0] wa;
    exp_t        e;
    idx  = a[7:4];
    wa   = {a[31:2], 2'b00};
    miss = predict_miss(a);
    if (miss) begin
      if (mvalid[idx] && mdirty[idx]) begin
        e.kind = 0;
        e.addr = {mtag[idx], idx, 4'h0};
        e.data = arch_line(e.addr);
        sbq.push_back(e);
      end
      e.kind = 1;
      e.addr = {a[31:4], 4'h0};
      e.data = '0;
      sbq.push_back(e);
      mvalid[idx] = 1'b1;
      mtag[idx]   = a[31:8];
      mdirty[idx] = 1'b0;
    end
    if (!abort) begin
      e.addr = a;
      if (we) begin
        arch[wa]    = d;
        mdirty[idx] = 1'b1;
        e.kind      = 3;
        e.data      = '0;
      end else begin
        e.kind = 2;
        e.data = {96'h0, arch_rd(wa)};
      end
      sbq.push_back(e);
    end
  endtask

  task automatic reset_model();
    mvalid = '0;
    mdirty = '0;
    arch   = bmem;
    sbq.delete();
  endtask

  task automatic do_op(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input string name);
    bit miss;
    int n;
    model_access(we, a, d, 1'b0, miss);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    @(negedge clk_i);
    chk({name, "_stall"}, {127'h0, stall_o}, {127'h0, miss});
    n = 0;
    while (stall_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (stall_o) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: stall_o still 1 after 200 cycles, required 0", name);
    end
    step();
    req_i = 1'b0;
    we_i  = 1'b0;
  endtask

  task automatic abort_op(input bit we, input logic [31:0] a, input logic [31:0] d);
    bit miss;
    int n;
    model_access(we, a, d, 1'b1, miss);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = a;
    wdata_i = d;
    @(negedge clk_i);
    chk("abort_stall", {127'h0, stall_o}, 128'h1);
    step();
    req_i = 1'b0;
    we_i  = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (stall_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (stall_o) begin
      checks++;
      errors++;
      $display("FAIL abort_timeout: stall_o still 1 after 200 cycles, required 0");
    end
    step();
  endtask

  // Backing memory: acks after a delay, sometimes pulses a stray ack while idle.
  always @(posedge clk_i) begin
    logic [31:0] wa;
    #1;
    if (rst_i) begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
    end else if (mem_ack_i) begin
      mem_ack_i = 1'b0;
      wait_cnt  = 0;
      cur_delay = pick_delay();
    end else if (mem_req_o) begin
      if (wait_cnt >= cur_delay) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) begin
          for (int w = 0; w < 4; w++) begin
            wa       = mem_addr_o + 32'(4 * w);
            bmem[wa] = mem_wdata_o[32*w +: 32];
          end
        end else begin
          mem_rdata_i = bm_line(mem_addr_o);
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt  = 0;
      cur_delay = pick_delay();
      if (spurious_en && $urandom_range(0, 7) == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  exp_t me;
  int   act_kind;

  always @(negedge clk_i) begin
    if (!rst_i && mem_req_o && mem_ack_i) begin
      checks++;
      act_kind = mem_we_o ? 0 : 1;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got kind %0d addr %h, required no transaction",
                 act_kind, mem_addr_o);
      end else begin
        me = sbq.pop_front();
        if (act_kind != me.kind || mem_addr_o !== me.addr ||
            (me.kind == 0 && mem_wdata_o !== me.data)) begin
          errors++;
          $display("FAIL mem_txn: got kind %0d addr %h wdata %h, expected kind %0d addr %h wdata %h",
                   act_kind, mem_addr_o, mem_wdata_o, me.kind, me.addr, me.data);
        end
      end
    end
    if (!rst_i && req_i && !stall_o) begin
      checks++;
      act_kind = we_i ? 3 : 2;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL cpu_unexpected: got kind %0d addr %h, required no completion",
                 act_kind, addr_i);
      end else begin
        me = sbq.pop_front();
        if (act_kind != me.kind || addr_i !== me.addr ||
            (me.kind == 2 && rdata_o !== me.data[31:0])) begin
          errors++;
          $display("FAIL cpu_resp: got kind %0d addr %h rdata %h, expected kind %0d addr %h data %h",
                   act_kind, addr_i, rdata_o, me.kind, me.addr, me.data[31:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  int          stall_cnt;
  int          n;
  bit          miss;
  bit          rwe;
  logic [31:0] ra;
  logic [31:0] rd;

  initial begin
    rst_i   = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 32'h0;
    wdata_i = 32'h0;
    mvalid  = '0;
    mdirty  = '0;
    #1 rst_i = 1'b1;
    #1;
    chk("rst_mem_req", {127'h0, mem_req_o}, 128'h0);
    chk("rst_mem_we", {127'h0, mem_we_o}, 128'h0);
    chk("rst_mem_addr", {96'h0, mem_addr_o}, 128'h0);
    chk("rst_mem_wdata", mem_wdata_o, 128'h0);
    chk("rst_rdata", {96'h0, rdata_o}, 128'h0);
    chk("rst_stall", {127'h0, stall_o}, 128'h0);
    step();
    step();
    rst_i = 1'b0;
    for (int w = 0; w < 4; w++) begin
      bmem[32'h100 + 32'(4 * w)] = 32'(w + 1);
      arch[32'h100 + 32'(4 * w)] = 32'(w + 1);
    end
    step();

    do_op(1'b0, 32'h100, 32'h0, "t1_cold_load");
    do_op(1'b0, 32'h104, 32'h0, "t2_hit_load");
    do_op(1'b1, 32'h108, 32'hAB, "t3_store_hit");
    do_op(1'b0, 32'h908, 32'h0, "t3_conflict_load");
    do_op(1'b1, 32'h200, 32'h55, "t4_store_miss");
    do_op(1'b0, 32'h200, 32'h0, "t4_load_merged");
    do_op(1'b0, 32'h100, 32'h0, "t4_evict_dirty");

    // Slow fetch while the CPU side scribbles on addr_i.
    fixed_delay = 20;
    step();
    model_access(1'b0, 32'h140, 32'h0, 1'b0, miss);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h140;
    @(negedge clk_i);
    chk("t6_stall_issue", {127'h0, stall_o}, 128'h1);
    stall_cnt = stall_o ? 1 : 0;
    step();
    for (int i = 0; i < 15; i++) begin
      addr_i = $urandom & 32'hFFFF_FFFC;
      @(negedge clk_i);
      chk("t6_stall_hold", {127'h0, stall_o}, 128'h1);
      chk("t6_mem_addr", {96'h0, mem_addr_o}, 128'h140);
      if (stall_o) stall_cnt++;
      step();
    end
    addr_i = 32'h140;
    n = 0;
    @(negedge clk_i);
    while (stall_o && n < 100) begin
      stall_cnt++;
      @(negedge clk_i);
      n++;
    end
    chk("t6_stall_cycles", {127'h0, stall_cnt >= 20}, 128'h1);
    step();
    req_i = 1'b0;
    fixed_delay = -1;

    // Reset while a line fetch is outstanding.
    fixed_delay = 1000;
    step();
    model_access(1'b0, 32'h0A0, 32'h0, 1'b0, miss);
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 32'h0A0;
    step();
    chk("t5_req_alloc", {127'h0, mem_req_o}, 128'h1);
    #2 rst_i = 1'b1;
    #1;
    chk("t5_req_rst", {127'h0, mem_req_o}, 128'h0);
    chk("t5_stall_rst", {127'h0, stall_o}, 128'h0);
    req_i = 1'b0;
    reset_model();
    step();
    rst_i = 1'b0;
    fixed_delay = -1;
    step();
    do_op(1'b0, 32'h100, 32'h0, "t5_load_after_rst");

    spurious_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      rwe = 1'($urandom_range(0, 1));
      ra  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
            (32'($urandom_range(0, 3)) << 2);
      rd  = $urandom;
      if (predict_miss(ra) && $urandom_range(0, 9) == 0) begin
        abort_op(rwe, ra, rd);
      end else begin
        do_op(rwe, ra, rd, "rnd");
      end
      repeat ($urandom_range(0, 2)) step();
    end
    spurious_en = 1'b0;
    repeat (5) step();
    chk("sb_empty", 128'(sbq.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
